exe_sched: RTL and testbench
============================

# exe_sched

Issue controller for the execute stage. Accepts one decoded instruction at a time from the decode/execute pipeline register. Single-cycle ALU and address ops complete immediately; mul/div/rem ops are sequenced through the shared multi-cycle MDU with a start/done handshake. Results are presented to writeback with valid/ready. The block also handles branch-redirect flush, an MDU watchdog and a stall counter.

## Interface
- `TIMEOUT`, default 64: maximum cycles the block waits for `mdu_done` after `mdu_start`.
- `CNT_W`, default 32: width of the stall counter.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: decode holds an instruction.
- `in_ready` out 1: instruction accepted on `in_valid & in_ready`.
- `op_class` in 2: 00 ALU, 01 MUL, 10 DIV/REM, 11 load/store address. Sampled on accept.
- `flush` in 1: branch redirect; kills any unretired op.
- `out_valid` out 1: result available to writeback.
- `out_ready` in 1: writeback consumes the result (wb_reg_finish).
- `mdu_start` out 1: one-cycle start pulse to the MDU.
- `mdu_done` in 1: MDU result ready, single-cycle pulse.
- `busy` out 1: state is not IDLE.
- `err` out 1: sticky MDU timeout flag.
- `stall_cnt` out CNT_W: cycles spent in ISSUE/WAIT/KILL. Wraps modulo 2^CNT_W.

## Operation
- States:
  - IDLE: empty.
  - ISSUE: pulses `mdu_start`.
  - WAIT: awaiting `mdu_done`.
  - HOLD: result held for writeback.
  - KILL: flushed op still running in the MDU.
- Reset values: state IDLE, `out_valid` 0, `mdu_start` 0, `busy` 0, `err` 0, `stall_cnt` 0, watchdog 0.
- `in_ready = ~flush & (IDLE | (HOLD & out_ready))`.
- `out_valid = (state==HOLD) & ~flush`.
- Accept with class ALU or address → HOLD.
- Accept with class MUL or DIV → ISSUE.
- ISSUE: `mdu_start`=1 for exactly this cycle; watchdog cleared; next state WAIT.
- WAIT:
  - `mdu_done` → HOLD.
  - Watchdog counts each WAIT cycle.
  - Watchdog reaches TIMEOUT without done → `err`←1 and state → IDLE; no `out_valid`.
- HOLD:
  - `out_ready` with no new accept → IDLE.
  - `out_ready` with a same-cycle accept → HOLD (ALU/addr) or ISSUE (MDU), giving back-to-back throughput.
  - `out_ready` low → stay in HOLD.
- Flush, per state:
  - IDLE: nothing accepted.
  - HOLD: → IDLE; the result is dropped and no transfer occurs.
  - ISSUE or WAIT without same-cycle `mdu_done` → KILL.
  - WAIT with same-cycle `mdu_done` → IDLE; the result is discarded.
  - KILL: stay in KILL.
- KILL:
  - `in_ready`=0.
  - Wait for `mdu_done`, which is discarded, then → IDLE.
  - Watchdog applies as in WAIT and ends in IDLE with `err` set.
- `mdu_done` seen in IDLE, ISSUE or HOLD is ignored.
- `err` clears only on `rst`.
- `stall_cnt` increments in every cycle whose state is ISSUE, WAIT or KILL.

## Timing
- All state, `mdu_start`, `err` and counters are registered.
- `out_valid` and `in_ready` are combinational only through `flush` and `out_ready`.
- ALU/address op: accept at edge k → `out_valid` in cycle k+1. Latency 1, throughput 1/cycle.
- MDU op: accept at edge k → `mdu_start` in cycle k+1.
- `mdu_done` at cycle d → `out_valid` in cycle d+1.
- Minimum MDU latency is 3 cycles, with `mdu_done` in the first WAIT cycle.
- Timeout: `err` is set at the edge ending the TIMEOUT-th WAIT/KILL cycle.
- `rst` mid-operation returns to IDLE on the next edge. No `mdu_start` is produced and any subsequent `mdu_done` is ignored.
- Simultaneous `flush` and `out_ready` in HOLD: flush wins; no transfer, and `out_valid` reads 0 that cycle.

## Structure
- Shared package `exe_pkg`:
  - state enum: IDLE, ISSUE, WAIT, HOLD, KILL.
  - `op_class` constants: OPC_ALU, OPC_MUL, OPC_DIV, OPC_MEM.
- One sub-module, `exe_wdog`: the clearable up-counter with terminal-count compare against TIMEOUT. It is reused for the WAIT and KILL watchdog.
- The FSM and `stall_cnt` live in the top level.

## Test plan
- Reset, then ALU ops on 3 consecutive cycles with `out_ready`=1: `out_valid` in cycles 1–3 after the first accept, `in_ready` stays 1, `stall_cnt`=0.
- MUL accepted, `mdu_done` 5 cycles after `mdu_start`: one `mdu_start` pulse, `out_valid` the cycle after done, `stall_cnt`=6, `busy` low after `out_ready`.
- DIV accepted, `flush` in the second WAIT cycle, `mdu_done` 4 cycles later: state KILL, `in_ready`=0, no `out_valid`, then IDLE.
- TIMEOUT=8 and `mdu_done` never arrives: `err`=1 after 8 WAIT cycles, state IDLE, `out_valid` never raised; `err` persists until `rst`.
- HOLD with `out_ready`=0 for 4 cycles: `out_valid` steady 1. Then `flush` and `out_ready` together: no transfer, next state IDLE.
- `rst` asserted in WAIT, then a stray `mdu_done`: all outputs at reset values and state stays IDLE.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared types for the execute-stage issue controller: FSM states and op classes.
package exe_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        KILL  = 3'd4
    } state_e;

    localparam logic [1:0] OPC_ALU = 2'b00;
    localparam logic [1:0] OPC_MUL = 2'b01;
    localparam logic [1:0] OPC_DIV = 2'b10;
    localparam logic [1:0] OPC_MEM = 2'b11;

    function automatic logic is_mdu_op(input logic [1:0] opc);
        return (opc == OPC_MUL) || (opc == OPC_DIV);
    endfunction

endpackage

// File: rtl/exe_wdog.sv
// MDU watchdog: clearable up-counter that flags the cycle in which the
// TIMEOUT-th enabled cycle completes.
module exe_wdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic term_c
);

    localparam int unsigned W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the cycles already spent, so TIMEOUT-1 marks the last allowed one
    assign term_c = en_i & (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/exe_sched.sv
// Execute-stage issue controller: single-cycle ops go straight to writeback,
// MDU ops are sequenced via start/done with flush-kill and a watchdog.
module exe_sched
    import exe_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op_class,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             mdu_start,
    input  logic             mdu_done,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt
);

    state_e           state_q, state_d;
    logic             err_q, err_d;
    logic             mdu_start_q;
    logic             busy_q;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             accept_c;
    logic             stalled_c;
    logic             wd_term_c;

    assign in_ready  = ~flush & ((state_q == IDLE) | ((state_q == HOLD) & out_ready));
    assign out_valid = (state_q == HOLD) & ~flush;
    assign accept_c  = in_valid & in_ready;
    assign stalled_c = (state_q == ISSUE) | (state_q == WAIT) | (state_q == KILL);

    exe_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q == ISSUE),
        .en_i   ((state_q == WAIT) | (state_q == KILL)),
        .term_c (wd_term_c)
    );

    // Next-state: done beats timeout, timeout beats flush while waiting on the MDU
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        stall_d = stall_q + CNT_W'(stalled_c);
        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = is_mdu_op(op_class) ? ISSUE : HOLD;
                end
            end
            ISSUE: begin
                state_d = flush ? KILL : WAIT;
            end
            WAIT: begin
                if (mdu_done) begin
                    state_d = flush ? IDLE : HOLD;
                end else if (wd_term_c) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (flush) begin
                    state_d = KILL;
                end
            end
            HOLD: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (out_ready) begin
                    if (accept_c) begin
                        state_d = is_mdu_op(op_class) ? ISSUE : HOLD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            KILL: begin
                if (mdu_done) begin
                    state_d = IDLE;
                end else if (wd_term_c) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            err_q       <= 1'b0;
            stall_q     <= '0;
            mdu_start_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            stall_q     <= stall_d;
            mdu_start_q <= (state_d == ISSUE);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign mdu_start = mdu_start_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_exe_sched.sv
// Directed scenarios plus randomized traffic against a transaction-level
// reference model of the execute-stage issue controller.
module tb_exe_sched;
    import exe_pkg::*;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst, in_valid, flush, out_ready, mdu_done;
    logic [1:0]  op_class;
    logic        in_ready, out_valid, mdu_start, busy, err;
    logic [31:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: what is pending, not how the controller encodes it
    bit          m_res;    // result waiting for writeback
    bit          m_iss;    // start pulse due this cycle
    bit          m_out;    // op outstanding inside the MDU
    bit          m_kill;   // outstanding op has been flushed
    bit          m_err;
    int unsigned m_age;    // cycles spent waiting on the outstanding op
    int unsigned m_stall;

    always #5 clk = ~clk;

    exe_sched #(.TIMEOUT(TO), .CNT_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_class  (op_class),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mdu_start (mdu_start),
        .mdu_done  (mdu_done),
        .busy      (busy),
        .err       (err),
        .stall_cnt (stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_res = 0; m_iss = 0; m_out = 0; m_kill = 0; m_err = 0; m_age = 0; m_stall = 0;
    endtask

    // One clock: drive, check outputs mid-cycle, then advance the model at the edge
    task automatic cyc(input bit v, input logic [1:0] opc, input bit fl, input bit ordy,
                       input bit dn, input bit r);
        bit exp_ir, acc;
        in_valid = v; op_class = opc; flush = fl; out_ready = ordy; mdu_done = dn; rst = r;
        @(negedge clk);
        exp_ir = !fl && ((!m_res && !m_iss && !m_out) || (m_res && ordy));
        check("in_ready",  32'(in_ready),  32'(exp_ir));
        check("out_valid", 32'(out_valid), 32'(m_res && !fl));
        check("mdu_start", 32'(mdu_start), 32'(m_iss));
        check("busy",      32'(busy),      32'(m_res || m_iss || m_out));
        check("err",       32'(err),       32'(m_err));
        check("stall_cnt", stall_cnt,      m_stall);
        acc = v && exp_ir;
        @(posedge clk);
        if (r) begin
            model_clear();
        end else begin
            if (m_iss || m_out) m_stall++;
            if (m_res && (fl || ordy)) m_res = 0;
            if (m_iss) begin
                m_iss = 0; m_out = 1; m_age = 0; m_kill = fl;
            end else if (m_out) begin
                m_age++;
                if (dn) begin
                    m_out = 0;
                    if (!m_kill && !fl) m_res = 1;
                end else if (m_age == TO) begin
                    m_out = 0; m_err = 1;
                end else if (fl) begin
                    m_kill = 1;
                end
            end
            if (acc) begin
                if (opc == OPC_MUL || opc == OPC_DIV) m_iss = 1;
                else m_res = 1;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, OPC_ALU, 0, 1, 0, 0);
    endtask

    initial begin
        int unsigned s0;
        rst = 1; in_valid = 0; op_class = OPC_ALU; flush = 0; out_ready = 0; mdu_done = 0;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        cyc(0, OPC_ALU, 0, 0, 0, 1);

        // Three back-to-back ALU/address ops
        cyc(1, OPC_ALU, 0, 1, 0, 0);
        cyc(1, OPC_MEM, 0, 1, 0, 0);
        cyc(1, OPC_ALU, 0, 1, 0, 0);
        idle(2);
        check("alu_stall", stall_cnt, 32'd0);

        // MUL with done five cycles after the start pulse
        s0 = m_stall;
        cyc(1, OPC_MUL, 0, 0, 0, 0);
        cyc(0, OPC_ALU, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, OPC_ALU, 0, 0, 0, 0);
        cyc(0, OPC_ALU, 0, 0, 1, 0);
        cyc(0, OPC_ALU, 0, 1, 0, 0);
        idle(1);
        check("mul_stall", stall_cnt, s0 + 32'd6);
        check("mul_busy", 32'(busy), 32'd0);

        // DIV flushed in the second WAIT cycle, done four cycles later
        cyc(1, OPC_DIV, 0, 0, 0, 0);
        cyc(0, OPC_ALU, 0, 0, 0, 0);
        cyc(0, OPC_ALU, 0, 0, 0, 0);
        cyc(0, OPC_ALU, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, OPC_ALU, 0, 1, 0, 0);
        cyc(1, OPC_ALU, 0, 0, 1, 0);
        idle(2);

        // MDU never answers: watchdog fires after TO wait cycles, err stays set
        cyc(1, OPC_MUL, 0, 1, 0, 0);
        for (int i = 0; i < 1 + TO; i++) cyc(0, OPC_ALU, 0, 1, 0, 0);
        idle(3);
        check("err_sticky", 32'(err), 32'd1);
        check("to_idle", 32'(busy), 32'd0);

        // Result held against back-pressure, then flush beats out_ready
        cyc(1, OPC_ALU, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, OPC_ALU, 0, 0, 0, 0);
        cyc(1, OPC_ALU, 1, 1, 0, 0);
        idle(1);
        check("flush_hold_idle", 32'(busy), 32'd0);

        // Reset while waiting on the MDU, then a stray done
        cyc(1, OPC_DIV, 0, 0, 0, 0);
        cyc(0, OPC_ALU, 0, 0, 0, 0);
        cyc(0, OPC_ALU, 0, 0, 0, 0);
        cyc(0, OPC_ALU, 0, 0, 0, 1);
        cyc(0, OPC_ALU, 0, 1, 1, 0);
        idle(2);
        check("rst_err", 32'(err), 32'd0);
        check("rst_stall", stall_cnt, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)),
                $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 4) == 0, $urandom_range(0, 149) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
